// File: rtl/input_cond_pkg.sv
// Shared constants and helpers for the input conditioner and its channels.
// Optional feature macro: INPUT_COND_INVERT_EN (per-channel output inversion).
package input_cond_pkg;

    // Default channel count and debounce window used when a parent does not override them.
    localparam int WIDTH_DEFAULT           = 4;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

    // Width of a counter that must hold values 0..cycles.
    // A floor of one bit keeps degenerate windows from producing a zero-width vector.
    function automatic int counterWidth(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : input_cond_pkg

// File: rtl/debounce_channel.sv
// One conditioned input: 2-flop synchroniser, stability counter, debounced
// state bit and registered rise/fall pulses on the (optionally inverted) output.
// Optional feature macro: INPUT_COND_INVERT_EN (applies INVERT to the output).
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit INVERT          = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_in,
    output logic o_out,
    output logic o_rise,
    output logic o_fall
);

    localparam int               CNT_W    = counterWidth(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef INPUT_COND_INVERT_EN
    localparam logic INV_BIT = INVERT;
`else
    // Inversion is disabled in this build; INVERT is masked off but still referenced.
    localparam logic INV_BIT = INVERT & 1'b0;
`endif

    logic             r_sync1;
    logic             r_sync2;
    logic             r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_rise;
    logic             r_fall;

    logic             w_mismatch;
    logic             w_toggle;
    logic             w_newOut;

    // Two-stage synchroniser: the raw pin is only ever seen through r_sync2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_in;
            r_sync2 <= r_sync1;
        end
    end

    // Decide whether the synchronised level differs from the held state and has
    // been different long enough to be accepted; also precompute the output
    // value that the state flip will produce so the pulses can be registered.
    always_comb begin
        w_mismatch = 1'b0;
        w_toggle   = 1'b0;
        w_newOut   = 1'b0;
        w_mismatch = r_sync2 ^ r_state;
        w_toggle   = w_mismatch && (r_count == CNT_LAST);
        w_newOut   = (~r_state) ^ INV_BIT;
    end

    // Counter and debounced state: any agreement clears the count, so a glitch
    // never accumulates; the count stops at CNT_LAST where the state flips.
    // The edge pulses are set on the same edge as the flip, so they line up
    // with the first cycle the output shows its new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= 1'b0;
            r_count <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (!w_mismatch) begin
                r_count <= '0;
            end else if (w_toggle) begin
                r_state <= ~r_state;
                r_count <= '0;
                r_rise  <= w_newOut;
                r_fall  <= ~w_newOut;
            end else begin
                r_count <= r_count + CNT_ONE;
            end
        end
    end

    assign o_out  = r_state ^ INV_BIT;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule : debounce_channel

// File: rtl/input_conditioner.sv
// Multi-channel debouncer for buttons and switches. Each bit of 'in' gets its
// own independent debounce_channel; outputs are the debounced levels plus
// one-cycle rise/fall pulses.
// Optional feature macro: INPUT_COND_INVERT_EN (enables INVERT_MASK).
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int               WIDTH           = WIDTH_DEFAULT,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic [WIDTH-1:0] INVERT_MASK     = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] w_out;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    // One fully independent channel per input bit.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : gen_channel
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INVERT          (INVERT_MASK[gi])
        ) u_channel (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_in   (in[gi]),
            .o_out  (w_out[gi]),
            .o_rise (w_rise[gi]),
            .o_fall (w_fall[gi])
        );
    end

    assign out  = w_out;
    assign rise = w_rise;
    assign fall = w_fall;

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with WIDTH=4, DEBOUNCE_CYCLES=4,
// INVERT_MASK=4'b0011. Expected output polarity follows INPUT_COND_INVERT_EN.
module tb_input_conditioner;

    localparam int         WIDTH = 4;
    localparam int         DEB   = 4;
    localparam logic [3:0] MASK  = 4'b0011;

`ifdef INPUT_COND_INVERT_EN
    localparam logic [3:0] EXP_MASK = MASK;
`else
    localparam logic [3:0] EXP_MASK = 4'b0000;
`endif

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    int checkCount;
    int failCount;

    input_conditioner #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB),
        .INVERT_MASK     (MASK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .out   (out),
        .rise  (rise),
        .fall  (fall)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and log mismatches.
    task automatic checkOutput(input string tag, input logic [3:0] actual, input logic [3:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %b expected %b", tag, actual, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] value);
        in = value;
    endtask

    // Advance n edges, OR-ing together every pulse seen on rise/fall.
    task automatic tickCollect(input int n, output logic [3:0] pulses);
        pulses = 4'b0000;
        for (int k = 0; k < n; k++) begin
            tick();
            pulses = pulses | rise | fall;
        end
    endtask

    // Drive a new level on 'in' from a settled state where the debounced state
    // equals oldState, and check the debounce latency and the edge pulses.
    task automatic checkTransition(input string tag, input logic [3:0] oldState, input logic [3:0] newState);
        logic [3:0] changed;
        logic [3:0] outNew;
        logic [3:0] pulses;
        changed = oldState ^ newState;
        outNew  = newState ^ EXP_MASK;
        applyStimulus(newState);
        tickCollect(DEB + 1, pulses);
        checkOutput({tag, "_hold_out"}, out, oldState ^ EXP_MASK);
        checkOutput({tag, "_hold_pulse"}, pulses, 4'b0000);
        tick();
        checkOutput({tag, "_out"}, out, outNew);
        checkOutput({tag, "_rise"}, rise, changed & outNew);
        checkOutput({tag, "_fall"}, fall, changed & ~outNew);
        tick();
        checkOutput({tag, "_post_pulse"}, rise | fall, 4'b0000);
        checkOutput({tag, "_post_out"}, out, outNew);
    endtask

    initial begin
        logic [3:0] pulses;
        checkCount = 0;
        failCount  = 0;

        // Reset held with a non-zero input pattern.
        rst_n = 1'b0;
        applyStimulus(4'b1010);
        #2;
        checkOutput("reset_async_out", out, EXP_MASK);
        tick();
        tick();
        tick();
        checkOutput("reset_out", out, EXP_MASK);
        checkOutput("reset_rise", rise, 4'b0000);
        checkOutput("reset_fall", fall, 4'b0000);

        // Release with inputs quiet: nothing may move for 10 cycles.
        applyStimulus(4'b0000);
        rst_n = 1'b1;
        tickCollect(10, pulses);
        checkOutput("release_pulses", pulses, 4'b0000);
        checkOutput("release_out", out, EXP_MASK);

        // Clean press and release on channel 2.
        checkTransition("press2", 4'b0000, 4'b0100);
        checkTransition("release2", 4'b0100, 4'b0000);

        // Glitch of 3 cycles on channel 3 must be rejected.
        applyStimulus(4'b1000);
        tickCollect(3, pulses);
        applyStimulus(4'b0000);
        begin
            logic [3:0] more;
            tickCollect(12, more);
            pulses = pulses | more;
        end
        checkOutput("glitch_pulses", pulses, 4'b0000);
        checkOutput("glitch_out", out, EXP_MASK);

        // Inverted channel 0.
        checkTransition("press0", 4'b0000, 4'b0001);
        checkTransition("release0", 4'b0001, 4'b0000);

        // All channels at once.
        checkTransition("all_on", 4'b0000, 4'b1111);
        checkTransition("all_off", 4'b1111, 4'b0000);

        // Reset in the middle of a channel 1 debounce.
        applyStimulus(4'b0010);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_async_out", out, EXP_MASK);
        checkOutput("midreset_pulse", rise | fall, 4'b0000);
        tick();
        rst_n = 1'b1;
        tickCollect(DEB + 1, pulses);
        checkOutput("midreset_hold_out", out, EXP_MASK);
        checkOutput("midreset_hold_pulse", pulses, 4'b0000);
        tick();
        checkOutput("midreset_out", out, 4'b0010 ^ EXP_MASK);
        checkOutput("midreset_rise", rise, 4'b0010 & (4'b0010 ^ EXP_MASK));
        checkOutput("midreset_fall", fall, 4'b0010 & ~(4'b0010 ^ EXP_MASK));

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule : tb_input_conditioner
